pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline stall/flush controller for the 5-stage core (pc, if, id, ex, mem, wb).
//  - Merges stall requests from the decode stage (load-use) and the execute stage.
//  - Sequences multi-cycle ex operations (div, madd) with an internal FSM and cycle counter.
//  - Drives the 6-bit stall vector to pc_reg and to every pipeline register; counts stalled cycles.
// PARAMETERS
//  MC_CNT_W  6  width of multi-cycle length input/counter (max 63 cycles)
// PORTS
//  clk             in   1          core clock
//  rst             in   1          synchronous, active-high reset (`RstEnable)
//  stallreq_id_i   in   1          decode requests stall (load-use hazard)
//  stallreq_ex_i   in   1          ex requests single-cycle stall
//  mc_start_i      in   1          ex begins multi-cycle op this cycle
//  mc_cycles_i     in   MC_CNT_W   length N of the multi-cycle op; sampled with mc_start_i
//  mc_cancel_i     in   1          abort in-flight multi-cycle op
//  flush_req_i     in   1          pipeline flush request (PIPE_CTRL_FLUSH_EN only)
//  stall_o         out  6          stall[0]=pc .. stall[5]=wb, 1 = hold stage
//  flush_o         out  1          clear if/id, id/ex, ex/mem registers
//  mc_busy_o       out  1          FSM in BUSY
//  mc_done_o       out  1          one-cycle pulse: multi-cycle result valid in ex
//  stall_cnt_o     out  32         stalled-cycle counter, saturating
// BEHAVIOUR
//  - Clock and reset: one clock clk; reset rst is synchronous and active-high.
//  - Reset: state=IDLE, counter=0, stall_cnt_o=0. While rst is high: stall_o=6'b000000,
//    flush_o=0, mc_busy_o=0, mc_done_o=0 (combinational outputs gated by rst).
//  - FSM states and transitions:
//    - IDLE: mc_start_i & N>0 -> BUSY, cnt<=N-1. mc_start_i & N==0 -> DONE.
//    - BUSY: cnt!=0 -> cnt<=cnt-1. cnt==0 -> DONE. mc_cancel_i -> IDLE (no done pulse).
//    - DONE: mc_done_o=1 -> IDLE. A mc_start_i in DONE is ignored; ex re-issues it.
//    - mc_start_i outside IDLE is ignored. mc_cancel_i outside BUSY is ignored.
//  - ex_stall = stallreq_ex_i | (IDLE & mc_start_i) | BUSY.
//  - Timing: start sampled in cycle T, N>0. Stall is held in cycles T..T+N (N+1 cycles).
//    mc_done_o is high in cycle T+N+1, and that cycle is not stalled by the FSM.
//  - stall_o priority, highest first:
//    - flush: 000000
//    - ex_stall: 001111
//    - stallreq_id_i: 000111
//    - otherwise: 000000
//    stall_o is combinational from inputs and state (zero-latency).
//  - stall_cnt_o: +1 at each edge where stall_o!=0. Holds at 32'hFFFF_FFFF. No wrap.
//  - mc_busy_o = (state==BUSY). Registered state, so it rises one cycle after the start.
// CONFIGURATION
//  PIPE_CTRL_FLUSH_EN defined:
//    - flush_o = flush_req_i & ~rst, and it overrides all stalls.
//    - A flush forces the FSM to IDLE next edge: in-flight op aborted, no done pulse.
//    - A flush in the same cycle as mc_start_i: the start is dropped.
//  PIPE_CTRL_FLUSH_EN undefined:
//    - flush_o tied 0; flush_req_i unused.
//    - The FSM is affected only by mc_cancel_i and rst.
// STRUCTURE
//  - defines.v: `StallNone 6'b000000, `StallFromId 6'b000111, `StallFromEx 6'b001111,
//    and the FSM state encodings `McIdle/`McBusy/`McDone (2 bits).
//  - Sub-module mc_seq: FSM + down-counter. Ports clk, rst, start, cycles, cancel, abort;
//    outputs busy, done, ex_stall.
//  - The top level holds the priority mux, flush gating and stall counter.
// TESTING
//  1. rst high 2 cycles with all requests high -> stall_o=0, flush_o=0, stall_cnt_o=0, mc_done_o=0.
//  2. stallreq_id_i=1 for 3 cycles -> stall_o=000111 for those cycles; stall_cnt_o=3.
//  3. mc_start_i, N=4, at T -> stall_o=001111 in T..T+4, mc_busy_o in T+1..T+4, mc_done_o at T+5 only.
//  4. N=0 start at T -> stall only in T; mc_done_o at T+1.
//     stallreq_id_i concurrent with BUSY -> stall_o=001111 (ex wins).
//  5. mc_cancel_i in 2nd BUSY cycle (N=8) -> IDLE next cycle, stall_o=0, no mc_done_o.
//     mc_start_i during BUSY ignored.
//  6. PIPE_CTRL_FLUSH_EN: flush_req_i mid-BUSY -> flush_o=1, stall_o=0 same cycle, IDLE next, no done.
//     Force stall_cnt_o=32'hFFFF_FFFE, stall 3 cycles -> counter holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The optional flush path is enabled with the PIPE_CTRL_FLUSH_EN macro.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_e;

    // stall bit 0 = pc ... bit 5 = wb; 1 holds the stage
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_FROM_ID = 6'b000111;
    localparam logic [5:0] STALL_FROM_EX = 6'b001111;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// Multi-cycle ex operation sequencer: IDLE/BUSY/DONE FSM with a down-counter.
// abort_i returns the FSM to IDLE from any state and drops a same-cycle start.
module mc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MC_CNT_W-1:0] cycles_i,
    input  logic                cancel_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                ex_stall_o
);

    mc_state_e           state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort_i) begin
            state_d = MC_IDLE;
        end else begin
            unique case (state_q)
                MC_IDLE: begin
                    if (start_i) begin
                        if (cycles_i != '0) begin
                            state_d = MC_BUSY;
                            cnt_d   = cycles_i - 1'b1;
                        end else begin
                            state_d = MC_DONE;
                        end
                    end
                end
                MC_BUSY: begin
                    // cancel wins even on the last busy cycle, so no done pulse follows
                    if (cancel_i) begin
                        state_d = MC_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = MC_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MC_DONE: state_d = MC_IDLE;
                default: state_d = MC_IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q == MC_BUSY);
    assign done_o     = (state_q == MC_DONE);
    assign ex_stall_o = busy_o | ((state_q == MC_IDLE) & start_i);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall priority mux, flush gating, saturating stall counter.
// Optional flush path: define PIPE_CTRL_FLUSH_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id_i,
    input  logic                stallreq_ex_i,
    input  logic                mc_start_i,
    input  logic [MC_CNT_W-1:0] mc_cycles_i,
    input  logic                mc_cancel_i,
    input  logic                flush_req_i,
    output logic [5:0]          stall_o,
    output logic                flush_o,
    output logic                mc_busy_o,
    output logic                mc_done_o,
    output logic [31:0]         stall_cnt_o
);

    logic        flush_act;
    logic        seq_busy, seq_done, seq_ex_stall;
    logic [5:0]  stall_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

`ifdef PIPE_CTRL_FLUSH_EN
    assign flush_act = flush_req_i & ~rst;
`else
    logic unused_flush_req;
    assign unused_flush_req = flush_req_i;
    assign flush_act        = 1'b0;
`endif

    mc_seq #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mc_start_i),
        .cycles_i   (mc_cycles_i),
        .cancel_i   (mc_cancel_i),
        .abort_i    (flush_act),
        .busy_o     (seq_busy),
        .done_o     (seq_done),
        .ex_stall_o (seq_ex_stall)
    );

    // Zero-latency priority: reset/flush, then ex, then decode
    always_comb begin
        stall_d = STALL_NONE;
        if (rst || flush_act) begin
            stall_d = STALL_NONE;
        end else if (seq_ex_stall || stallreq_ex_i) begin
            stall_d = STALL_FROM_EX;
        end else if (stallreq_id_i) begin
            stall_d = STALL_FROM_ID;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d != STALL_NONE) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_o     = stall_d;
    assign flush_o     = flush_act;
    assign mc_busy_o   = seq_busy & ~rst;
    assign mc_done_o   = seq_done & ~rst;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle model pushes expected outputs, sampled outputs pop them.
// Flush scenarios run only when PIPE_CTRL_FLUSH_EN is defined.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0;
    logic        mc_start_i = 1'b0, mc_cancel_i = 1'b0, flush_req_i = 1'b0;
    logic [5:0]  mc_cycles_i = '0;
    logic [5:0]  stall_o;
    logic        flush_o, mc_busy_o, mc_done_o;
    logic [31:0] stall_cnt_o;

    pipe_ctrl #(.MC_CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .mc_start_i    (mc_start_i),
        .mc_cycles_i   (mc_cycles_i),
        .mc_cancel_i   (mc_cancel_i),
        .flush_req_i   (flush_req_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .mc_busy_o     (mc_busy_o),
        .mc_done_o     (mc_done_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    exp_t exp_q[$];

    // Cycle model: busy_left = BUSY cycles still to come, done_pend = done pulse owed this cycle
    int          m_busy_left = 0;
    bit          m_done_pend = 1'b0;
    logic [31:0] m_cnt       = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit idr, input bit exr, input bit st,
                        input logic [5:0] n, input bit can, input bit fl);
        exp_t e;
        exp_t s;
        bit   idle, fl_eff, exs;
        @(negedge clk);
        rst = r; stallreq_id_i = idr; stallreq_ex_i = exr; mc_start_i = st;
        mc_cycles_i = n; mc_cancel_i = can; flush_req_i = fl;

        idle   = (m_busy_left == 0) && !m_done_pend;
        fl_eff = FLUSH_EN && fl && !r;
        exs    = exr || (idle && st) || (m_busy_left > 0);
        if (r || fl_eff)  e.stall = 6'b000000;
        else if (exs)     e.stall = 6'b001111;
        else if (idr)     e.stall = 6'b000111;
        else              e.stall = 6'b000000;
        e.flush = fl_eff;
        e.busy  = !r && (m_busy_left > 0);
        e.done  = !r && m_done_pend;
        e.cnt   = m_cnt;
        exp_q.push_back(e);

        #1;
        s = exp_q.pop_front();
        check("stall_o",     64'(stall_o),     64'(s.stall));
        check("flush_o",     64'(flush_o),     64'(s.flush));
        check("mc_busy_o",   64'(mc_busy_o),   64'(s.busy));
        check("mc_done_o",   64'(mc_done_o),   64'(s.done));
        check("stall_cnt_o", 64'(stall_cnt_o), 64'(s.cnt));

        // advance the model to the state after the coming edge
        if (r) begin
            m_busy_left = 0; m_done_pend = 1'b0; m_cnt = '0;
        end else begin
            if (e.stall != 6'b0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (fl_eff) begin
                m_busy_left = 0; m_done_pend = 1'b0;
            end else if (m_done_pend) begin
                m_done_pend = 1'b0;
            end else if (m_busy_left > 0) begin
                if (can) m_busy_left = 0;
                else begin
                    m_busy_left--;
                    if (m_busy_left == 0) m_done_pend = 1'b1;
                end
            end else if (st) begin
                if (n == 6'd0) m_done_pend = 1'b1;
                else           m_busy_left = int'(n);
            end
        end
        cyc++;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 6'd0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        // reset with every request high
        step(1, 1, 1, 1, 6'd4, 1, 1);
        step(1, 1, 1, 1, 6'd4, 1, 1);
        idle_steps(1);

        // decode load-use stall, 3 cycles
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 6'd0, 0, 0);
        idle_steps(1);
        check("cnt_after_id", 64'(stall_cnt_o), 64'd3);

        // N=4 multi-cycle op
        step(0, 0, 0, 1, 6'd4, 0, 0);
        idle_steps(6);

        // N=0 op, then N=3 op with concurrent decode stall
        step(0, 0, 0, 1, 6'd0, 0, 0);
        idle_steps(2);
        step(0, 0, 0, 1, 6'd3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 6'd0, 0, 0);
        idle_steps(2);

        // N=8 op: start ignored in 1st busy cycle, cancel in 2nd
        step(0, 0, 0, 1, 6'd8, 0, 0);
        step(0, 0, 0, 1, 6'd2, 0, 0);
        step(0, 0, 0, 0, 6'd0, 1, 0);
        idle_steps(3);
        check("busy_after_cancel", 64'(mc_busy_o), 64'd0);

        // single-cycle ex stall over a decode stall; cancel and start in DONE ignored
        step(0, 1, 1, 0, 6'd0, 0, 0);
        step(0, 0, 1, 0, 6'd0, 0, 0);
        step(0, 0, 0, 1, 6'd1, 0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 0);
        step(0, 0, 0, 1, 6'd5, 1, 0);
        idle_steps(2);

        // flush mid-busy, and flush coincident with a start
        step(0, 0, 0, 1, 6'd5, 0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 0);
        step(0, 1, 0, 0, 6'd0, 0, 1);
        idle_steps(3);
        step(0, 0, 1, 1, 6'd2, 0, 1);
        idle_steps(4);
        check("flush_pins", 64'({mc_busy_o, mc_done_o}), 64'd0);

        // counter saturation
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 6'd0, 0, 0);
        idle_steps(1);
        check("cnt_saturated", 64'(stall_cnt_o), 64'hFFFF_FFFF);
        step(1, 0, 0, 0, 6'd0, 0, 0);
        idle_steps(1);

        // random mix
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 6'($urandom_range(0, 6)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
